// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type, data width and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

    localparam int UART_DATA_BITS = 8;

    function automatic int uart_clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with flush, occupancy level and full/empty flags.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full ignores a same-cycle pop so a full FIFO never accepts
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit after the data bits).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [UART_DATA_BITS-1:0]     data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          flush_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int CPB = uart_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);

    if (CPB < 2) begin : g_bad_baud
        $error("uart_tx_buffered: clocks per bit must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_tx_state_e              state, state_n;
    logic [CW-1:0]               baud_cnt, baud_cnt_n;
    logic [2:0]                  bit_cnt, bit_cnt_n;
    logic [UART_DATA_BITS-1:0]   byte_q;
    logic [UART_DATA_BITS-1:0]   fifo_data;
    logic                        tx_q, tx_n;
    logic                        pop;
    logic                        baud_last;
    logic                        fifo_full;
    logic                        fifo_empty;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (valid_i),
        .pop   (pop),
        .flush (flush_i),
        .wdata (data_i),
        .rdata (fifo_data),
        .level (fifo_level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_last = baud_cnt == CW'(CPB - 1);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                pop     = !fifo_empty;
                state_n = fifo_empty ? IDLE : START;
            end
            START: state_n = baud_last ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   state_n = (baud_last && bit_cnt == 3'(UART_DATA_BITS - 1)) ? PARITY : DATA;
            PARITY: state_n = baud_last ? STOP : PARITY;
`else
            DATA:   state_n = (baud_last && bit_cnt == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
`endif
            STOP: if (baud_last) begin
                pop     = !fifo_empty;
                state_n = fifo_empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
        baud_cnt_n = (state == IDLE || state_n != state || baud_last) ? '0 : baud_cnt + CW'(1);
        bit_cnt_n  = (state == DATA && baud_last) ? bit_cnt + 3'd1 : bit_cnt;
        // tx is registered from the current state, so the line lags the FSM by one cycle
`ifdef UART_TX_PARITY_EN
        tx_n = state == START  ? 1'b0 :
               state == DATA   ? byte_q[bit_cnt] :
               state == PARITY ? ^byte_q : 1'b1;
`else
        tx_n = state == START ? 1'b0 :
               state == DATA  ? byte_q[bit_cnt] : 1'b1;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            byte_q   <= pop ? fifo_data : byte_q;
            tx_q     <= tx_n;
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = !fifo_full;
    assign busy_o  = state != IDLE || fifo_level_o != '0;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized checks of the buffered UART transmitter against a frame-level model.
module tb_uart_tx_buffered;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = CPB * NBITS;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_level_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    uart_tx_buffered #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    // line level for bit-time idx of a frame carrying b: start, 8 data LSB first, [parity], stop
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NBITS == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic recv_frame(input logic [7:0] b, output int st);
        logic [FL-1:0] obs_v;
        logic [FL-1:0] exp_v;
        int n = 0;
        @(negedge clk);
        while (tx_o !== 1'b0 && n < 4 * FL) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 4 * FL) begin
            n_bad++;
            $display("FAIL start_timeout: tx_o=%b after %0d cycles, required a start bit for byte %h", tx_o, n, b);
            st = -1;
            return;
        end
        st = cyc;
        for (int c = 0; c < FL; c++) begin
            if (c > 0) @(negedge clk);
            obs_v[c] = tx_o;
            exp_v[c] = exp_bit(b, c / CPB);
        end
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL frame_%h: observed %h required %h", b, obs_v, exp_v);
        end
    endtask

    task automatic rx_frames(input int nfr);
        int st;
        int prev = 0;
        logic [7:0] b;
        for (int k = 0; k < nfr; k++) begin
            b = exp_q.pop_front();
            recv_frame(b, st);
            if (k > 0) begin
                n_cmp++;
                if (st - prev != FL) begin
                    n_bad++;
                    $display("FAIL frame_gap: start-to-start %0d cycles, required %0d", st - prev, FL);
                end
            end
            prev = st;
        end
    endtask

    task automatic check_idle(input int n);
        logic saw_low = 1'b0;
        logic saw_busy = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) saw_low = 1'b1;
            if (busy_o !== 1'b0) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_low) begin
            n_bad++;
            $display("FAIL idle_tx: tx_o left 1 while idle, required 1");
        end
        n_cmp++;
        if (saw_busy) begin
            n_bad++;
            $display("FAIL idle_busy: busy_o was 1 while idle, required 0");
        end
    endtask

    task automatic push_burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            data_i  = bytes[i];
            valid_i = 1'b1;
            @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_tx: %b required 1", tx_o); end
        if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: %b required 1", ready_o); end
        if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: %b required 0", busy_o); end
        if (fifo_level_o !== 3'd0) begin n_bad++; $display("FAIL reset_level: %0d required 0", fifo_level_o); end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int t;
        int st;
        data_i  = 8'hA5;
        valid_i = 1'b1;
        @(negedge clk);
        t = cyc;
        valid_i = 1'b0;
        recv_frame(8'hA5, st);
        n_cmp++;
        if (st - t != 2) begin
            n_bad++;
            $display("FAIL first_start_latency: %0d cycles, required 2", st - t);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: %b required 0", busy_o); end
        check_idle(5);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[$] = '{8'h00, 8'hFF};
        exp_q = bytes;
        fork
            push_burst(bytes);
            rx_frames(2);
        join
        check_idle(5);
    endtask

    task automatic test_fill;
        logic [7:0] bytes[$];
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
        exp_q = bytes[0:4];
        fork
            begin
                foreach (bytes[i]) begin
                    data_i  = bytes[i];
                    valid_i = 1'b1;
                    @(negedge clk);
                end
                n_cmp += 2;
                if (fifo_level_o !== 3'd4) begin n_bad++; $display("FAIL fill_level: %0d required 4", fifo_level_o); end
                if (ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_ready: %b required 0", ready_o); end
                repeat (3) @(negedge clk);
                n_cmp++;
                if (fifo_level_o !== 3'd4) begin n_bad++; $display("FAIL fill_hold_level: %0d required 4", fifo_level_o); end
                valid_i = 1'b0;
            end
            rx_frames(5);
        join
        check_idle(2 * FL);
    endtask

    task automatic test_flush;
        logic [7:0] bytes[$];
        int p1 = 0;
        for (int i = 0; i < 5; i++) bytes.push_back(8'($urandom));
        exp_q = bytes[0:1];
        fork
            begin
                foreach (bytes[i]) begin
                    data_i  = bytes[i];
                    valid_i = 1'b1;
                    @(negedge clk);
                    if (i == 0) p1 = cyc;
                end
                valid_i = 1'b0;
                while (cyc < p1 + FL + 30) @(negedge clk);
                n_cmp++;
                if (fifo_level_o !== 3'd3) begin n_bad++; $display("FAIL preflush_level: %0d required 3", fifo_level_o); end
                flush_i = 1'b1;
                valid_i = 1'b1;
                data_i  = 8'h5A;
                @(negedge clk);
                flush_i = 1'b0;
                valid_i = 1'b0;
                n_cmp++;
                if (fifo_level_o !== 3'd0) begin n_bad++; $display("FAIL flush_level: %0d required 0", fifo_level_o); end
            end
            rx_frames(2);
        join
        check_idle(2 * FL);
    endtask

    task automatic test_parity;
        logic [7:0] bytes[$] = '{8'h07, 8'h03};
        exp_q = bytes;
        fork
            push_burst(bytes);
            rx_frames(2);
        join
        check_idle(5);
    endtask

    task automatic test_random;
        logic [7:0] bytes[$];
        for (int r = 0; r < 3; r++) begin
            bytes = {};
            for (int i = 0; i < int'($urandom_range(1, DEPTH + 1)); i++) bytes.push_back(8'($urandom));
            exp_q = bytes;
            fork
                push_burst(bytes);
                rx_frames(bytes.size());
            join
            check_idle(3);
        end
    endtask

    task automatic test_reset_mid_frame;
        data_i  = 8'h00;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b0) begin n_bad++; $display("FAIL midframe_pre: tx_o=%b required 0", tx_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp += 3;
        if (tx_o !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx: %b required 1", tx_o); end
        if (busy_o !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: %b required 0", busy_o); end
        if (fifo_level_o !== 3'd0) begin n_bad++; $display("FAIL async_reset_level: %0d required 0", fifo_level_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        check_idle(2 * FL);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_fill;
        test_flush;
        test_parity;
        test_random;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
